text_fetch: RTL

TEXT_FETCH -- requirements
Module: text_fetch

---
 rtl/text_fetch_if.sv | 27 ++
 rtl/text_fetch.sv | 108 ++++++++++
 2 files changed

// File: rtl/text_fetch_if.sv
// Pixel-side and memory-side signals of the text_fetch character pipeline.
// The slave modport is the text_fetch view; master is the timing/memory side.
interface text_fetch_if;
   logic [9:0]  px_x;
   logic [9:0]  px_y;
   logic        in_active;
   logic        in_hsync;
   logic        in_vsync;
   logic [11:0] ram_addr;
   logic [7:0]  ram_data;
   logic [11:0] font_addr;
   logic [7:0]  font_data;
   logic        pix_on;
   logic        out_active;
   logic        out_hsync;
   logic        out_vsync;

   modport slave (
      input  px_x, px_y, in_active, in_hsync, in_vsync, ram_data, font_data,
      output ram_addr, font_addr, pix_on, out_active, out_hsync, out_vsync
   );

   modport master (
      output px_x, px_y, in_active, in_hsync, in_vsync, ram_data, font_data,
      input  ram_addr, font_addr, pix_on, out_active, out_hsync, out_vsync
   );
endinterface

// File: rtl/text_fetch.sv
// Four-stage text-mode pixel fetch: screen RAM -> font ROM -> pixel, 4 clk latency.
// Optional reverse video for codes 0x80-0xFF when TEXT_REVERSE_VIDEO_EN is defined.
module text_fetch #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 30
) (
   input logic         clk,
   input logic         rst,
   text_fetch_if.slave bus
);

   localparam logic [10:0] X_LIM = 11'(COLS * 8);
   localparam logic [10:0] Y_LIM = 11'(ROWS * 16);

   logic [3:0]  r_vld;
   logic [11:0] r_ram_addr;
   logic [3:0]  r_line1, r_line2;
   logic [2:0]  r_bit1, r_bit2, r_bit3;
   logic        r_blank1, r_blank2, r_blank3;
   // sideband packed as {active, hsync, vsync}
   logic [2:0]  r_side1, r_side2, r_side3;
   logic        r_pix4, r_act4, r_hs4, r_vs4;
`ifdef TEXT_REVERSE_VIDEO_EN
   logic        r_rev3;
`endif

   logic        w_blank;
   logic        w_glyph_bit;
   logic        w_pix;

   assign w_blank = ~bus.in_active
                  | ({1'b0, bus.px_x} >= X_LIM)
                  | ({1'b0, bus.px_y} >= Y_LIM);

   assign bus.ram_addr = r_ram_addr;

`ifdef TEXT_REVERSE_VIDEO_EN
   assign bus.font_addr = {1'b0, bus.ram_data[6:0], r_line2};
`else
   assign bus.font_addr = {bus.ram_data, r_line2};
`endif

   // font_data is the ROM's own output register, so it stands as the stage-3 data copy
   always_comb begin
      w_glyph_bit = bus.font_data[3'd7 - r_bit3];
`ifdef TEXT_REVERSE_VIDEO_EN
      w_pix = (w_glyph_bit ^ r_rev3) & ~r_blank3;
`else
      w_pix = w_glyph_bit & ~r_blank3;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld      <= '0;
         r_ram_addr <= '0;
         r_line1    <= '0;
         r_line2    <= '0;
         r_bit1     <= '0;
         r_bit2     <= '0;
         r_bit3     <= '0;
         r_blank1   <= 1'b0;
         r_blank2   <= 1'b0;
         r_blank3   <= 1'b0;
         r_side1    <= '0;
         r_side2    <= '0;
         r_side3    <= '0;
         r_pix4     <= 1'b0;
         r_act4     <= 1'b0;
         r_hs4      <= 1'b1;
         r_vs4      <= 1'b1;
`ifdef TEXT_REVERSE_VIDEO_EN
         r_rev3     <= 1'b0;
`endif
      end else begin
         r_vld      <= {r_vld[2:0], 1'b1};
         r_ram_addr <= {bus.px_y[8:4], bus.px_x[9:3]};
         r_line1    <= bus.px_y[3:0];
         r_bit1     <= bus.px_x[2:0];
         r_blank1   <= w_blank;
         r_side1    <= {bus.in_active, bus.in_hsync, bus.in_vsync};

         r_line2    <= r_line1;
         r_bit2     <= r_bit1;
         r_blank2   <= r_blank1;
         r_side2    <= r_side1;

         r_bit3     <= r_bit2;
         r_blank3   <= r_blank2;
         r_side3    <= r_side2;
`ifdef TEXT_REVERSE_VIDEO_EN
         r_rev3     <= bus.ram_data[7];
`endif

         r_pix4     <= w_pix;
         r_act4     <= r_side3[2];
         r_hs4      <= r_side3[1];
         r_vs4      <= r_side3[0];
      end
   end

   // outputs hold idle values until the first post-reset sample reaches stage 4
   assign bus.pix_on     = r_vld[3] & r_pix4;
   assign bus.out_active = r_vld[3] & r_act4;
   assign bus.out_hsync  = ~r_vld[3] | r_hs4;
   assign bus.out_vsync  = ~r_vld[3] | r_vs4;

endmodule
